hitomezashi_pattern_gen: RTL and testbench



---
 rtl/hitomezashi_pattern_gen_if.sv | 33 +++
 rtl/hitomezashi_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_hitomezashi_pattern_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hitomezashi_pattern_gen_if.sv
// Hitomezashi pattern generator port bundle: request pulses in, committed
// stitch start vectors and status out.
interface hitomezashi_pattern_gen_if #(
    parameter int V_LINES = 40,
    parameter int H_LINES = 22
);
    logic               frame;
    logic               advance;
    logic [V_LINES-1:0] v_start;
    logic [H_LINES-1:0] h_start;
    logic               busy;
    logic               update;

    // Timing/control side: issues frame and advance, consumes the pattern.
    modport master (
        output frame,
        output advance,
        input  v_start,
        input  h_start,
        input  busy,
        input  update
    );

    // Generator side.
    modport slave (
        input  frame,
        input  advance,
        output v_start,
        output h_start,
        output busy,
        output update
    );
endinterface

// File: rtl/hitomezashi_pattern_gen.sv
// Hitomezashi stitch start-vector generator. A 16-bit Fibonacci LFSR fills
// shadow registers one bit per cycle; the shadow is committed to the outputs
// only on a frame pulse so a frame never mixes two patterns.
module hitomezashi_pattern_gen #(
    parameter int                 V_LINES = 40,
    parameter int                 H_LINES = 22,
    parameter logic [15:0]        SEED    = 16'hACE1,
    parameter int                 FRAMES  = 60,
    parameter logic [V_LINES-1:0] V_INIT  = V_LINES'({V_LINES{2'b01}}),
    parameter logic [H_LINES-1:0] H_INIT  = H_LINES'({H_LINES{2'b01}})
) (
    input  logic                      clk_pix,
    input  logic                      rst_pix_n,
    hitomezashi_pattern_gen_if.slave  pg
);

    localparam int                 TOTAL    = V_LINES + H_LINES;
    localparam int                 IDX_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(TOTAL - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0]        SEED_EFF = (SEED == 16'd0) ? 16'h0001 : SEED;
    localparam logic [15:0]        FR_LAST  = (FRAMES == 0) ? 16'd0 : 16'(FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [15:0]        lfsr;
    logic [15:0]        frame_cnt;
    logic [IDX_W-1:0]   idx;
    logic [V_LINES-1:0] shadow_v;
    logic [H_LINES-1:0] shadow_h;
    logic [V_LINES-1:0] v_start_q;
    logic [H_LINES-1:0] h_start_q;
    logic               update_q;

    logic               fb;
    logic               frame_term;
    logic               trig;
    logic               start;
    logic               gen_en;
    logic               commit;

    // Taps 16,15,13,4; the feedback bit is both the shifted-in bit and the
    // emitted pattern bit.
    assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];

    // advance and the terminal frame in the same cycle collapse into one trigger.
    assign frame_term = (FRAMES != 0) && (frame_cnt == FR_LAST);
    assign trig       = pg.advance || (pg.frame && frame_term);

    // State register.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; requests outside IDLE are dropped.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        gen_en    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig) begin
                    start     = 1'b1;
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                gen_en = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pg.frame) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame counter: counts frame pulses only while idle, restarts on a trigger.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            frame_cnt <= 16'd0;
        end else if (start) begin
            frame_cnt <= 16'd0;
        end else if (state == S_IDLE && pg.frame) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Bit index into the concatenated shadow {h, v}.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (gen_en) begin
            idx <= idx + 1'b1;
        end
    end

    // LFSR steps only while generating, keeping the pattern sequence deterministic.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            lfsr <= SEED_EFF;
        end else if (gen_en) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    // Shadow fill: first V_LINES bits go to vertical lines, the rest to horizontal.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            shadow_v <= '0;
            shadow_h <= '0;
        end else if (gen_en) begin
            for (int i = 0; i < V_LINES; i++) begin
                if (idx == IDX_W'(i)) begin
                    shadow_v[i] <= fb;
                end
            end
            for (int j = 0; j < H_LINES; j++) begin
                if (idx == IDX_W'(V_LINES + j)) begin
                    shadow_h[j] <= fb;
                end
            end
        end
    end

    // Output registers: change only on the commit edge; update marks that edge.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            v_start_q <= V_INIT;
            h_start_q <= H_INIT;
            update_q  <= 1'b0;
        end else begin
            update_q <= commit;
            if (commit) begin
                v_start_q <= shadow_v;
                h_start_q <= shadow_h;
            end
        end
    end

    assign pg.v_start = v_start_q;
    assign pg.h_start = h_start_q;
    assign pg.update  = update_q;
    assign pg.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_hitomezashi_pattern_gen.sv
// Self-checking bench for hitomezashi_pattern_gen: one instance with automatic
// regeneration disabled and one with FRAMES=3, checked against an LFSR model
// through per-instance expected-pattern queues.
module tb_hitomezashi_pattern_gen;

    localparam int          V_LINES = 40;
    localparam int          H_LINES = 22;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk_pix;
    logic rst_pix_n;

    hitomezashi_pattern_gen_if #(.V_LINES(V_LINES), .H_LINES(H_LINES)) ifa ();
    hitomezashi_pattern_gen_if #(.V_LINES(V_LINES), .H_LINES(H_LINES)) ifb ();

    hitomezashi_pattern_gen #(
        .V_LINES(V_LINES), .H_LINES(H_LINES), .SEED(SEED), .FRAMES(0)
    ) dut_a (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pg        (ifa.slave)
    );

    hitomezashi_pattern_gen #(
        .V_LINES(V_LINES), .H_LINES(H_LINES), .SEED(SEED), .FRAMES(3)
    ) dut_b (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pg        (ifb.slave)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    // Alternating 1010... with index 0 = 1.
    logic [V_LINES-1:0] v_init = 40'h55_5555_5555;
    logic [H_LINES-1:0] h_init = 22'h15_5555;

    int n_total = 0;
    int n_bad   = 0;
    int upd_a   = 0;
    int upd_b   = 0;

    logic [15:0] lfsr_a;
    logic [15:0] lfsr_b;
    logic [61:0] exp_q_a[$];
    logic [61:0] exp_q_b[$];
    logic [61:0] last_a;
    logic [61:0] last_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR: 62 steps, bit i is the i-th emitted feedback bit.
    task automatic model_gen(inout logic [15:0] q, output logic [61:0] pat);
        logic f;
        for (int i = 0; i < 62; i++) begin
            f      = q[15] ^ q[14] ^ q[12] ^ q[3];
            q      = {q[14:0], f};
            pat[i] = f;
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Scoreboard consumers and output-stability watch, sampled mid-cycle.
    always @(negedge clk_pix) begin
        logic [61:0] e;
        if (!rst_pix_n) begin
            last_a = {ifa.h_start, ifa.v_start};
            last_b = {ifb.h_start, ifb.v_start};
        end else begin
            if (ifa.update) begin
                upd_a++;
                if (exp_q_a.size() == 0) begin
                    check("a_unexpected_update", 64'd1, 64'd0);
                end else begin
                    e = exp_q_a.pop_front();
                    check("a_v_start", 64'(ifa.v_start), 64'(e[39:0]));
                    check("a_h_start", 64'(ifa.h_start), 64'(e[61:40]));
                end
            end else if ({ifa.h_start, ifa.v_start} != last_a) begin
                check("a_stable", 64'({ifa.h_start, ifa.v_start}), 64'(last_a));
            end
            if (ifb.update) begin
                upd_b++;
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_update", 64'd1, 64'd0);
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_v_start", 64'(ifb.v_start), 64'(e[39:0]));
                    check("b_h_start", 64'(ifb.h_start), 64'(e[61:40]));
                end
            end else if ({ifb.h_start, ifb.v_start} != last_b) begin
                check("b_stable", 64'({ifb.h_start, ifb.v_start}), 64'(last_b));
            end
            last_a = {ifa.h_start, ifa.v_start};
            last_b = {ifb.h_start, ifb.v_start};
        end
    end

    initial begin
        logic [61:0]        p;
        logic [61:0]        first_pat;
        logic [V_LINES-1:0] vs;

        rst_pix_n   = 1'b0;
        ifa.frame   = 1'b0;
        ifa.advance = 1'b0;
        ifb.frame   = 1'b0;
        ifb.advance = 1'b0;
        lfsr_a      = SEED;
        lfsr_b      = SEED;

        // Reset values
        repeat (3) tick();
        check("rst_a_v", 64'(ifa.v_start), 64'(v_init));
        check("rst_a_h", 64'(ifa.h_start), 64'(h_init));
        check("rst_a_busy", 64'(ifa.busy), 64'd0);
        check("rst_a_update", 64'(ifa.update), 64'd0);
        check("rst_b_v", 64'(ifb.v_start), 64'(v_init));
        rst_pix_n = 1'b1;
        repeat (2) tick();

        // FRAMES=0: frame pulses alone never regenerate
        for (int k = 0; k < 5; k++) begin
            ifa.frame = 1'b1;
            tick();
            ifa.frame = 1'b0;
            repeat (20) tick();
        end
        check("f0_v_unchanged", 64'(ifa.v_start), 64'(v_init));
        check("f0_h_unchanged", 64'(ifa.h_start), 64'(h_init));
        check("f0_busy", 64'(ifa.busy), 64'd0);
        check("f0_no_update", 64'(upd_a), 64'd0);

        // Single advance; frames during GEN and advances in GEN/WAIT are ignored
        model_gen(lfsr_a, p);
        exp_q_a.push_back(p);
        first_pat   = p;
        ifa.advance = 1'b1;
        tick();
        ifa.advance = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            ifa.frame   = (c == 10 || c == 62);
            ifa.advance = (c == 30 || c == 66);
            tick();
            if (c == 1)  check("busy_t1", 64'(ifa.busy), 64'd1);
            if (c == 62) check("busy_gen_last", 64'(ifa.busy), 64'd1);
            if (c == 62) check("v_stable_gen", 64'(ifa.v_start), 64'(v_init));
        end
        ifa.frame   = 1'b0;
        ifa.advance = 1'b0;
        check("no_commit_in_gen", 64'(upd_a), 64'd0);
        check("busy_wait", 64'(ifa.busy), 64'd1);

        ifa.frame = 1'b1;
        tick();
        ifa.frame = 1'b0;
        vs = ifa.v_start;
        check("commit_update", 64'(ifa.update), 64'd1);
        check("commit_busy", 64'(ifa.busy), 64'd0);
        check("v_start_bit0", 64'(vs[0]), 64'd1);
        check("v_start_bit1", 64'(vs[1]), 64'd0);
        tick();
        check("update_one_cycle", 64'(ifa.update), 64'd0);
        check("one_commit", 64'(upd_a), 64'd1);

        // Second pattern: earliest commit frame, with advance coinciding in WAIT
        model_gen(lfsr_a, p);
        exp_q_a.push_back(p);
        ifa.advance = 1'b1;
        tick();
        ifa.advance = 1'b0;
        repeat (62) tick();
        ifa.frame   = 1'b1;
        ifa.advance = 1'b1;
        tick();
        ifa.frame   = 1'b0;
        ifa.advance = 1'b0;
        check("commit2_update", 64'(ifa.update), 64'd1);
        repeat (3) tick();
        check("advance_not_queued", 64'(ifa.busy), 64'd0);
        check("two_commits", 64'(upd_a), 64'd2);

        // Reset mid-GEN discards the partial pattern and restarts the sequence
        model_gen(lfsr_a, p);
        exp_q_a.push_back(p);
        ifa.advance = 1'b1;
        tick();
        ifa.advance = 1'b0;
        repeat (29) tick();
        #2;
        rst_pix_n = 1'b0;
        #1;
        check("rst_async_v", 64'(ifa.v_start), 64'(v_init));
        check("rst_async_h", 64'(ifa.h_start), 64'(h_init));
        check("rst_async_busy", 64'(ifa.busy), 64'd0);
        void'(exp_q_a.pop_back());
        lfsr_a = SEED;
        lfsr_b = SEED;
        tick();
        rst_pix_n = 1'b1;
        tick();
        model_gen(lfsr_a, p);
        exp_q_a.push_back(first_pat);
        ifa.advance = 1'b1;
        tick();
        ifa.advance = 1'b0;
        repeat (65) tick();
        ifa.frame = 1'b1;
        tick();
        ifa.frame = 1'b0;
        tick();
        check("commits_after_reset", 64'(upd_a), 64'd3);

        // FRAMES=3: commit on every 4th widely spaced frame pulse
        for (int k = 1; k <= 10; k++) begin
            ifb.frame = 1'b1;
            tick();
            ifb.frame = 1'b0;
            if (k == 3 || k == 7) begin
                model_gen(lfsr_b, p);
                exp_q_b.push_back(p);
                check($sformatf("b_busy_k%0d", k), 64'(ifb.busy), 64'd1);
            end
            check($sformatf("b_update_k%0d", k), 64'(ifb.update), 64'((k % 4) == 0));
            repeat (79) tick();
        end
        check("b_commits", 64'(upd_b), 64'd2);
        check("a_queue_empty", 64'(exp_q_a.size()), 64'd0);
        check("b_queue_empty", 64'(exp_q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
